// File: rtl/pipe_scoreboard_if.sv
// pipe_scoreboard_if: ID-stage hazard query and scoreboard response bundle
interface pipe_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_wb_en;
  logic                  id_mem_r;
  logic                  flush;
  logic                  mem_stall;
  logic                  freeze;
  logic [1:0]            fwd_sel1;
  logic [1:0]            fwd_sel2;
  logic [CNT_W-1:0]      stall_cnt;
  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r, flush, mem_stall,
    input  freeze, fwd_sel1, fwd_sel2, stall_cnt
  );
  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r, flush, mem_stall,
    output freeze, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: in-flight destination tracker producing freeze and forwarding selects
module pipe_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  pipe_scoreboard_if.slave sb
);
  localparam logic [DEPTH-1:0] raw_mask = {1'b0, {(DEPTH-1){1'b1}}};
  logic [DEPTH-1:0]      v, wb, m1, m2;
  logic [REG_ADDR_W-1:0] dst [DEPTH];
  logic                  mr0;
  logic                  hazard, issue;
  logic [1:0]            sel1, sel2, nxt_sel1, nxt_sel2;
  logic [CNT_W-1:0]      cnt;
  // per-slot producer match against both ID sources
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m1[k] = v[k] & wb[k] & (dst[k] == sb.id_src1);
      m2[k] = v[k] & wb[k] & (dst[k] == sb.id_src2) & sb.id_two_src;
    end
  end
  // forwarding only needs a freeze for load-use; otherwise any non-WB producer stalls
  assign hazard = sb.id_valid & ((FWD_EN != 0) ? mr0 & (m1[0] | m2[0]) : |((m1 | m2) & raw_mask));
  assign issue  = sb.id_valid & ~hazard & ~sb.flush;
  // youngest producer wins: EXE result comes from MEM, older one from WB
  always_comb begin
    nxt_sel1 = (FWD_EN != 0 && issue) ? (m1[0] ? 2'd1 : m1[1] ? 2'd2 : 2'd0) : 2'd0;
    nxt_sel2 = (FWD_EN != 0 && issue) ? (m2[0] ? 2'd1 : m2[1] ? 2'd2 : 2'd0) : 2'd0;
  end
  // slot shift register and registered selects; a memory stall freezes everything
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v    <= '0;
      wb   <= '0;
      mr0  <= 1'b0;
      dst  <= '{default: '0};
      sel1 <= 2'd0;
      sel2 <= 2'd0;
    end else if (!sb.mem_stall) begin
      v      <= {v[DEPTH-2:0], issue};
      wb     <= {wb[DEPTH-2:0], sb.id_wb_en};
      mr0    <= sb.id_mem_r;
      dst[0] <= sb.id_dest;
      for (int k = 1; k < DEPTH; k++) dst[k] <= dst[k-1];
      sel1   <= nxt_sel1;
      sel2   <= nxt_sel2;
    end
  // saturating count of frozen cycles
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (sb.freeze && !(&cnt)) cnt <= cnt + 1'b1;
  assign sb.freeze    = rst & (hazard | sb.mem_stall);
  assign sb.fwd_sel1  = sel1;
  assign sb.fwd_sel2  = sel2;
  assign sb.stall_cnt = cnt;
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed vectors with a queued scoreboard over three configurations
module tb_pipe_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, id_two_src, id_wb_en, id_mem_r, flush, mem_stall;
  logic [3:0] id_src1, id_src2, id_dest;
  always #5 clk = ~clk;
  pipe_scoreboard_if #(.REG_ADDR_W(4), .CNT_W(16)) if_f ();
  pipe_scoreboard_if #(.REG_ADDR_W(4), .CNT_W(16)) if_n ();
  pipe_scoreboard_if #(.REG_ADDR_W(4), .CNT_W(2))  if_s ();
  assign {if_f.id_valid,   if_n.id_valid,   if_s.id_valid}   = {3{id_valid}};
  assign {if_f.id_src1,    if_n.id_src1,    if_s.id_src1}    = {3{id_src1}};
  assign {if_f.id_src2,    if_n.id_src2,    if_s.id_src2}    = {3{id_src2}};
  assign {if_f.id_two_src, if_n.id_two_src, if_s.id_two_src} = {3{id_two_src}};
  assign {if_f.id_dest,    if_n.id_dest,    if_s.id_dest}    = {3{id_dest}};
  assign {if_f.id_wb_en,   if_n.id_wb_en,   if_s.id_wb_en}   = {3{id_wb_en}};
  assign {if_f.id_mem_r,   if_n.id_mem_r,   if_s.id_mem_r}   = {3{id_mem_r}};
  assign {if_f.flush,      if_n.flush,      if_s.flush}      = {3{flush}};
  assign {if_f.mem_stall,  if_n.mem_stall,  if_s.mem_stall}  = {3{mem_stall}};
  pipe_scoreboard #(.REG_ADDR_W(4), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) dut_f (.clk(clk), .rst(rst), .sb(if_f));
  pipe_scoreboard #(.REG_ADDR_W(4), .DEPTH(3), .FWD_EN(0), .CNT_W(16)) dut_n (.clk(clk), .rst(rst), .sb(if_n));
  pipe_scoreboard #(.REG_ADDR_W(4), .DEPTH(3), .FWD_EN(1), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .sb(if_s));
  typedef struct {int d; int k; int v; string n;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  localparam int FRZ = 0, S1 = 1, S2 = 2, CNT = 3;
  function automatic int act(int d, int k);
    if (d == 0) return k == FRZ ? int'(if_f.freeze) : k == S1 ? int'(if_f.fwd_sel1) : k == S2 ? int'(if_f.fwd_sel2) : int'(if_f.stall_cnt);
    if (d == 1) return k == FRZ ? int'(if_n.freeze) : k == S1 ? int'(if_n.fwd_sel1) : k == S2 ? int'(if_n.fwd_sel2) : int'(if_n.stall_cnt);
    return k == FRZ ? int'(if_s.freeze) : k == S1 ? int'(if_s.fwd_sel1) : k == S2 ? int'(if_s.fwd_sel2) : int'(if_s.stall_cnt);
  endfunction
  // monitor: drain every expectation queued for this cycle, away from the rising edge
  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      int a;
      e = q.pop_front();
      a = act(e.d, e.k);
      n_cmp++;
      if (a !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d", e.n, a, e.v);
      end
    end
  function automatic void ex(int d, int k, int v, string n);
    q.push_back('{d, k, v, n});
  endfunction
  task automatic drv(input logic v, input int s1, input int s2, input logic two, input int d,
                     input logic wb, input logic mr, input logic fl, input logic ms);
    id_valid = v; id_src1 = 4'(s1); id_src2 = 4'(s2); id_two_src = two; id_dest = 4'(d);
    id_wb_en = wb; id_mem_r = mr; flush = fl; mem_stall = ms;
  endtask
  task automatic ins(input int s1, input int s2, input logic two, input int d, input logic mr);
    drv(1'b1, s1, s2, two, d, 1'b1, mr, 1'b0, 1'b0);
  endtask
  task automatic bub();
    drv(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bub();
    tick();
    rst = 1'b1;
  endtask
  initial begin
    // held in reset with a memory stall requested: freeze stays low
    drv(1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b1);
    ex(0, FRZ, 0, "rst_frz"); ex(0, S1, 0, "rst_sel1"); ex(0, S2, 0, "rst_sel2"); ex(0, CNT, 0, "rst_cnt");
    tick();
    // forwarding: distance 1, distance 2, youngest wins, r0 ordinary
    do_reset();
    ins(1, 2, 1, 3, 0); ex(0, FRZ, 0, "a_add_frz"); tick();
    ins(3, 4, 1, 6, 0); ex(0, FRZ, 0, "a_sub_frz"); tick();
    bub(); ex(0, S1, 1, "a_d1_sel1"); ex(0, S2, 0, "a_d1_sel2"); tick();
    bub(); ex(0, S1, 0, "a_bub_sel1"); tick();
    ins(0, 0, 0, 7, 0); tick();
    ins(1, 2, 0, 8, 0); tick();
    ins(7, 0, 0, 9, 0); ex(0, FRZ, 0, "a_d2_frz"); tick();
    bub(); ex(0, S1, 2, "a_d2_sel1"); ex(0, S2, 0, "a_d2_sel2"); tick();
    ins(1, 1, 0, 10, 0); tick();
    ins(1, 1, 0, 10, 0); tick();
    ins(10, 10, 1, 11, 0); tick();
    bub(); ex(0, S1, 1, "a_young_sel1"); ex(0, S2, 1, "a_young_sel2"); tick();
    ins(1, 1, 0, 0, 0); tick();
    ins(0, 1, 1, 12, 0); tick();
    bub(); ex(0, S1, 1, "a_r0_sel1"); ex(0, S2, 0, "a_r0_sel2"); tick();
    // load-use on src2: one freeze cycle then forward from WB
    do_reset();
    ins(1, 0, 0, 5, 1); ex(0, FRZ, 0, "b_ldr_frz"); tick();
    ins(1, 5, 1, 6, 0); ex(0, FRZ, 1, "b_lu_frz"); tick();
    ins(1, 5, 1, 6, 0); ex(0, FRZ, 0, "b_lu_frz2"); ex(0, CNT, 1, "b_cnt"); ex(0, S2, 0, "b_bub_sel2"); tick();
    bub(); ex(0, S1, 0, "b_sel1"); ex(0, S2, 2, "b_sel2"); ex(0, CNT, 1, "b_cnt2"); tick();
    // no forwarding: RAW freezes DEPTH-1 cycles, WB slot and unread src2 ignored
    do_reset();
    ins(1, 3, 1, 2, 0); ex(1, FRZ, 0, "c_add_frz"); tick();
    ins(2, 4, 1, 5, 0); ex(1, FRZ, 1, "c_raw_frz1"); ex(1, S1, 0, "c_sel1"); tick();
    ins(2, 4, 1, 5, 0); ex(1, FRZ, 1, "c_raw_frz2"); tick();
    ins(2, 4, 1, 5, 0); ex(1, FRZ, 0, "c_wb_frz"); ex(1, CNT, 2, "c_cnt"); tick();
    bub(); ex(1, S1, 0, "c_nf_sel1"); ex(1, S2, 0, "c_nf_sel2"); tick();
    ins(1, 3, 1, 2, 0); ex(1, FRZ, 0, "c_indep_frz"); tick();
    ins(4, 2, 0, 6, 0); ex(1, FRZ, 0, "c_two0_frz"); tick();
    ins(1, 2, 1, 7, 0); ex(1, FRZ, 1, "c_slot1_frz"); tick();
    // flush: flushed instructions leave bubbles behind
    do_reset();
    ins(1, 0, 0, 5, 1); tick();
    drv(1'b1, 5, 0, 1'b0, 6, 1'b1, 1'b0, 1'b1, 1'b0); ex(0, FRZ, 1, "d_flush_haz_frz"); tick();
    drv(1'b1, 1, 0, 1'b0, 6, 1'b1, 1'b1, 1'b1, 1'b0); ex(0, FRZ, 0, "d_after_frz"); ex(0, S1, 0, "d_flush_sel1"); tick();
    ins(6, 5, 1, 7, 0); ex(0, FRZ, 0, "d_flushed_ld_frz"); tick();
    bub(); ex(0, S1, 0, "d_sel1"); ex(0, S2, 0, "d_sel2"); tick();
    // memory stall with flush held: state frozen, shift resumes afterwards
    do_reset();
    ins(1, 2, 0, 3, 0); tick();
    ins(3, 2, 0, 4, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 4, 0, 1'b0, 9, 1'b1, 1'b0, 1'b1, 1'b1);
      ex(0, FRZ, 1, "e_ms_frz"); ex(0, S1, 1, "e_ms_sel1"); ex(0, CNT, i, "e_ms_cnt");
      tick();
    end
    ins(4, 3, 1, 9, 0); ex(0, FRZ, 0, "e_post_frz"); ex(0, CNT, 3, "e_cnt3"); ex(0, S1, 1, "e_hold_sel1"); tick();
    bub(); ex(0, S1, 1, "e_shift_sel1"); ex(0, S2, 2, "e_shift_sel2"); ex(0, CNT, 3, "e_cnt_keep"); tick();
    // asynchronous reset with a full pipe and nonzero outputs
    ins(0, 0, 0, 1, 0); tick();
    ins(1, 0, 0, 2, 0); tick();
    ins(2, 0, 0, 3, 1); ex(0, S1, 1, "g_pre_sel1"); ex(0, CNT, 3, "g_pre_cnt"); tick();
    rst = 1'b0;
    ins(3, 0, 0, 4, 0);
    ex(0, FRZ, 0, "g_rst_frz"); ex(0, S1, 0, "g_rst_sel1"); ex(0, S2, 0, "g_rst_sel2"); ex(0, CNT, 0, "g_rst_cnt");
    tick();
    rst = 1'b1;
    ex(0, FRZ, 0, "g_post_rst_frz"); tick();
    bub(); ex(0, S1, 0, "g_post_rst_sel1"); tick();
    // 2-bit counter saturates
    do_reset();
    drv(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    ex(2, CNT, 3, "f_cnt3"); ex(2, FRZ, 1, "f_frz");
    tick(); tick();
    bub(); ex(2, CNT, 3, "f_sat");
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised hazard/forwarding scoreboard for the ARM 5-stage pipeline; replaces the purely combinational hazard detector.
- Keeps a shift-register record of in-flight destinations from EXE onward and generates `freeze` toward IF/ID.
- Produces registered forwarding selects that travel with each instruction into EXE.
- Supports a memory-stall input, branch flush, configurable pipeline depth, and forwarding on/off.

Parameters:
- REG_ADDR_W, 4, width of register specifiers.
- DEPTH, 3, tracked slots after ID (slot0=EXE, slot1=MEM, slot2=WB); minimum 2.
- FWD_EN, 1, 1 = forwarding mode (only load-use freezes); 0 = freeze on any RAW hazard.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src1  in  REG_ADDR_W  Rn of ID instruction
- id_src2  in  REG_ADDR_W  second source (Rm or Rd for store)
- id_two_src  in  1  src2 is actually read
- id_dest  in  REG_ADDR_W  destination of ID instruction
- id_wb_en  in  1  ID instruction writes back
- id_mem_r  in  1  ID instruction is a load
- flush  in  1  branch taken in EXE
- mem_stall  in  1  memory stage not ready; whole pipe holds
- freeze  out  1  hold PC and IF/ID register
- fwd_sel1  out  2  EXE operand1 source: 0 regfile, 1 MEM ALU result, 2 WB value
- fwd_sel2  out  2  same for operand2
- stall_cnt  out  CNT_W  saturating count of freeze cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - all slots invalid;
  - fwd_sel1 = fwd_sel2 = 0;
  - stall_cnt = 0;
  - freeze = 0 while in reset.
- Slot content: valid, dest, wb_en, mem_r.
- match(k, s) = slot k valid & wb_en & dest == s. Register 0 is not special.
- src2 comparisons apply only when id_two_src = 1. Comparisons apply only when id_valid = 1.
- Hazard, FWD_EN=0: match on any slot 0..DEPTH-2. Slot DEPTH-1 (WB) is excluded; the register file is write-before-read.
- Hazard, FWD_EN=1: match on slot0 with slot0.mem_r = 1 (load-use) only.
- freeze (combinational) = hazard | mem_stall.
- Priority on each rising edge:
  - mem_stall = 1: hold all slots, fwd_sel and everything else; flush is ignored that cycle (upstream keeps flush high while the branch remains in EXE).
  - Else: shift slot k into slot k+1 (slot DEPTH-1 retires).
  - slot0 loads the ID instruction if id_valid & !hazard & !flush; otherwise slot0 becomes a bubble.
- fwd_sel update (FWD_EN=1, no mem_stall, instruction issued):
  - Computed from pre-shift slots: slot0 match → 1; else slot1 match → 2; else 0. Youngest producer wins.
  - Registered, so it is valid during the instruction's EXE cycle.
- fwd_sel on bubble or flush: 0. With FWD_EN=0: fwd_sel is constant 0.
- stall_cnt: +1 on each edge where freeze = 1; saturates at all-ones, no wrap.
- Latency:
  - freeze is same-cycle combinational from ID inputs and slot state;
  - fwd_sel has 1 cycle latency.
- A load-use freeze lasts exactly 1 cycle (absent mem_stall).
- With FWD_EN=0, a hazard on slot0 lasts DEPTH-1 cycles.

Test Plan:
- Reset mid-run with slots full → all outputs 0 immediately; the next instruction with a matching src sees no freeze.
- FWD_EN=1: ADD r3 then SUB with src1=r3 → no freeze, fwd_sel1=1 in SUB's EXE cycle. With one independent instruction between → fwd_sel1=2.
- FWD_EN=1: LDR r5 then ADD src2=r5, two_src=1 → freeze for 1 cycle, stall_cnt=1, then fwd_sel2=2 for the ADD.
- FWD_EN=0, DEPTH=3: ADD r2 then ADD src1=r2 → freeze 2 cycles, fwd_sel stays 0. The same pair with two_src=0 and dependence only on src2 → no freeze.
- flush=1 with a hazard present → slot0 becomes a bubble, fwd_sel=0, and the next cycle shows no freeze from the flushed instruction.
- mem_stall held 3 cycles with flush=1 → slots and fwd_sel unchanged, freeze=1, stall_cnt +3. The pipe shifts on the first cycle after mem_stall deasserts. Saturation check: CNT_W=2 over 5 freeze cycles → stall_cnt=3.
